// File: rtl/pc_seq_unit.sv
// Program-counter sequencer with jal/jump/ret/branch handling and a small
// circular return-address stack whose overflow and underflow set a sticky error flag.
module pc_seq_unit #(
  parameter int                 WIDTH     = 16,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jalEN,
  input  logic             jumpEN,
  input  logic             retEN,
  input  logic             branchEN,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] Rlink,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasErr
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] PC_TWO   = WIDTH'(2);

  logic [WIDTH-1:0] pcReg, pcNext;
  logic [WIDTH-1:0] linkReg, linkNext;
  logic [PTR_W-1:0] wrPtrReg, wrPtrNext;
  logic [CNT_W-1:0] countReg, countNext;
  logic             errReg;
  logic             errSet;
  logic             doPush, doPop;
  logic [PTR_W-1:0] topIdx;
  logic [WIDTH-1:0] pcPlus1;
  logic [WIDTH-1:0] rasMem [RAS_DEPTH];

  assign pc       = pcReg;
  assign Rlink    = linkReg;
  assign rasErr   = errReg;
  assign rasEmpty = (countReg == '0);
  assign rasFull  = (countReg == FULL_CNT);

  // The write pointer names the next free slot, so the top entry sits one behind it.
  assign topIdx  = (wrPtrReg == '0) ? LAST_IDX : (wrPtrReg - PTR_ONE);
  assign pcPlus1 = pcReg + PC_ONE;

  always_comb begin
    pcNext    = pcPlus1;
    linkNext  = linkReg;
    doPush    = 1'b0;
    doPop     = 1'b0;
    errSet    = 1'b0;
    wrPtrNext = wrPtrReg;
    countNext = countReg;

    if (jalEN) begin
      pcNext   = src2;
      linkNext = pcPlus1;
      doPush   = 1'b1;
      errSet   = rasFull;
    end else if (jumpEN) begin
      pcNext = src2;
    end else if (retEN) begin
      if (!rasEmpty) begin
        pcNext = rasMem[topIdx];
        doPop  = 1'b1;
      end else begin
        errSet = 1'b1;
      end
    end else if (branchEN) begin
      pcNext = pcReg + src2 - PC_TWO;
    end

    // When full, the push lands on the oldest slot, so only the pointer advances.
    if (doPush) begin
      wrPtrNext = (wrPtrReg == LAST_IDX) ? '0 : (wrPtrReg + PTR_ONE);
      countNext = rasFull ? countReg : (countReg + CNT_ONE);
    end else if (doPop) begin
      wrPtrNext = topIdx;
      countNext = countReg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcReg    <= RESET_PC;
      linkReg  <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
      errReg   <= 1'b0;
    end else if (!stall) begin
      pcReg    <= pcNext;
      linkReg  <= linkNext;
      wrPtrReg <= wrPtrNext;
      countReg <= countNext;
      errReg   <= errReg | errSet;
    end
  end

  // Stack contents carry no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (reset && !stall && doPush) begin
      rasMem[wrPtrReg] <= pcPlus1;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomized and directed checks of pc_seq_unit against a queue-based
// reference model of the PC and return-address stack.
module tb_pc_seq_unit;

  localparam int          WIDTH     = 16;
  localparam int          RAS_DEPTH = 4;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, stall, jalEN, jumpEN, retEN, branchEN;
  logic [15:0] src2;
  logic [15:0] pc, Rlink;
  logic        rasEmpty, rasFull, rasErr;

  int vectors     = 0;
  int miscompares = 0;
  int cycleNum    = 0;

  // Reference model state
  logic [15:0] mPc;
  logic [15:0] mLink;
  logic        mErr;
  logic [15:0] mStack[$];

  pc_seq_unit #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .jalEN   (jalEN),
    .jumpEN  (jumpEN),
    .retEN   (retEN),
    .branchEN(branchEN),
    .src2    (src2),
    .pc      (pc),
    .Rlink   (Rlink),
    .rasEmpty(rasEmpty),
    .rasFull (rasFull),
    .rasErr  (rasErr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNum);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic rst, input logic stl, input logic jal, input logic jmp,
                      input logic ret, input logic br, input logic [15:0] s2);
    reset = rst; stall = stl; jalEN = jal; jumpEN = jmp;
    retEN = ret; branchEN = br; src2 = s2;
    @(posedge clk);
    cycleNum++;
    if (!rst) begin
      mPc = RESET_PC;
      mLink = 16'h0;
      mErr = 1'b0;
      mStack.delete();
    end else if (!stl) begin
      if (jal) begin
        mLink = mPc + 16'd1;
        mStack.push_back(mPc + 16'd1);
        if (mStack.size() > RAS_DEPTH) begin
          void'(mStack.pop_front());
          mErr = 1'b1;
        end
        mPc = s2;
      end else if (jmp) begin
        mPc = s2;
      end else if (ret) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin
          mPc = mPc + 16'd1;
          mErr = 1'b1;
        end
      end else if (br) begin
        mPc = mPc + s2 - 16'd2;
      end else begin
        mPc = mPc + 16'd1;
      end
    end
    #1;
    $display("cyc %0d rst=%b stl=%b jal=%b jmp=%b ret=%b br=%b src2=%h -> pc=%h link=%h e=%b f=%b err=%b",
             cycleNum, rst, stl, jal, jmp, ret, br, s2, pc, Rlink, rasEmpty, rasFull, rasErr);
    checkVal("pc", {16'h0, pc}, {16'h0, mPc});
    checkVal("Rlink", {16'h0, Rlink}, {16'h0, mLink});
    checkVal("rasEmpty", {31'h0, rasEmpty}, {31'h0, (mStack.size() == 0)});
    checkVal("rasFull", {31'h0, rasFull}, {31'h0, (mStack.size() == RAS_DEPTH)});
    checkVal("rasErr", {31'h0, rasErr}, {31'h0, mErr});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic doReset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jalEN = 1'b0; jumpEN = 1'b0;
    retEN = 1'b0; branchEN = 1'b0; src2 = 16'h0;
    mPc = RESET_PC; mLink = 16'h0; mErr = 1'b0;

    // Reset state, sequential run and stall hold
    doReset();
    checkVal("rst_pc", {16'h0, pc}, 32'h0);
    checkVal("rst_empty", {31'h0, rasEmpty}, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      checkVal("seq_pc", {16'h0, pc}, i);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      checkVal("stall_pc", {16'h0, pc}, 32'h3);
    end

    // Call and return from pc=5
    idle(); idle();
    checkVal("pre_call_pc", {16'h0, pc}, 32'h5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
    checkVal("call_pc", {16'h0, pc}, 32'h40);
    checkVal("call_link", {16'h0, Rlink}, 32'h6);
    checkVal("call_empty", {31'h0, rasEmpty}, 32'h0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkVal("ret_pc", {16'h0, pc}, 32'h6);
    checkVal("ret_empty", {31'h0, rasEmpty}, 32'h1);

    // Backward branch and PC wrap
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC);
    checkVal("branch_pc", {16'h0, pc}, 32'h000A);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    idle();
    checkVal("wrap_pc", {16'h0, pc}, 32'h0);

    // Overflow: five nested calls, then unwind
    doReset();
    idle();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(11 + 10 * i));
    checkVal("ovf_full", {31'h0, rasFull}, 32'h1);
    checkVal("ovf_err", {31'h0, rasErr}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      checkVal("unwind_pc", {16'h0, pc}, 32'(42 - 10 * i));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkVal("underflow_pc", {16'h0, pc}, 32'd13);
    checkVal("underflow_err", {31'h0, rasErr}, 32'h1);

    // Priority: all requests together, then ret+branch
    doReset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020);
    checkVal("prio_pc", {16'h0, pc}, 32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100);
    checkVal("prio_ret_pc", {16'h0, pc}, 32'h1);
    checkVal("prio_one_push", {31'h0, rasEmpty}, 32'h1);

    // Reset mid-call discards stack and error
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500);
    checkVal("midrst_pc", {16'h0, pc}, {16'h0, RESET_PC});
    checkVal("midrst_empty", {31'h0, rasEmpty}, 32'h1);
    checkVal("midrst_err", {31'h0, rasErr}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkVal("midrst_ret_pc", {16'h0, pc}, {16'h0, RESET_PC + 16'd1});
    checkVal("midrst_ret_err", {31'h0, rasErr}, 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
